// File: rtl/ctech_lib_sync_pkg.sv
// Shared constants and helpers for the multi-bit synchronizer/filter.
//   MAX_STAGES     : deepest supported synchronizer chain
//   MAX_FILTER_CNT : largest supported stability count
//   filt_cnt_w(n)  : width of a counter that must hold 0..n (minimum 1 bit)
package ctech_lib_sync_pkg;

  localparam int unsigned MAX_STAGES     = 4;
  localparam int unsigned MAX_FILTER_CNT = 255;

  function automatic int unsigned filt_cnt_w(int n);
    if (n < 1) return 1;
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ctech_lib_multisync_filt_bit.sv
// One channel of the multi-bit synchronizer: STAGES-deep sync chain,
// stability filter and registered edge pulses.
// Ports:
//   clk  : destination clock
//   rstb : asynchronous active-low reset
//   d    : asynchronous level input
//   o    : synchronized, filtered level
//   rise : one-cycle pulse when o goes 0->1
//   fall : one-cycle pulse when o goes 1->0
module ctech_lib_multisync_filt_bit
  import ctech_lib_sync_pkg::*;
#(
  parameter int unsigned STAGES     = 2,
  parameter int unsigned FILTER_CNT = 0,
  parameter logic        RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rstb,
  input  logic d,
  output logic o,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = filt_cnt_w(int'(FILTER_CNT));
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CNT);

  logic [STAGES-1:0] sync;
  logic              s;
  logic [CW-1:0]     cnt;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync <= {STAGES{RST_VAL}};
    end else begin
      sync <= {sync[STAGES-2:0], d};
    end
  end

  assign s = sync[STAGES-1];

  // The counter measures how many consecutive edges s has disagreed with o;
  // o only follows once the disagreement has lasted FILTER_CNT+1 edges.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      o    <= RST_VAL;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == o) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        o    <= s;
        cnt  <= '0;
        rise <= s;
        fall <= ~s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ctech_lib_multisync_filt.sv
// Parametrised multi-bit synchronizer for asynchronous level inputs with
// per-bit reset value, optional stability filter and edge pulses.
// Ports:
//   clk     : destination clock
//   rstb    : asynchronous active-low reset
//   d       : asynchronous data inputs (WIDTH)
//   o       : synchronized, filtered levels (WIDTH)
//   rise    : per-bit one-cycle pulse on o 0->1 (WIDTH)
//   fall    : per-bit one-cycle pulse on o 1->0 (WIDTH)
//   any_chg : OR of all rise and fall bits
module ctech_lib_multisync_filt
  import ctech_lib_sync_pkg::*;
#(
  parameter int unsigned      WIDTH      = 1,
  parameter int unsigned      STAGES     = 2,
  parameter logic [WIDTH-1:0] RST_VAL    = '0,
  parameter int unsigned      FILTER_CNT = 0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_chg
);

  if (WIDTH < 1) begin : g_chk_width
    $error("ctech_lib_multisync_filt: WIDTH must be at least 1");
  end
  if (STAGES < 2 || STAGES > MAX_STAGES) begin : g_chk_stages
    $error("ctech_lib_multisync_filt: STAGES must be in 2..4");
  end
  if (FILTER_CNT > MAX_FILTER_CNT) begin : g_chk_filt
    $error("ctech_lib_multisync_filt: FILTER_CNT must be in 0..255");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ctech_lib_multisync_filt_bit #(
      .STAGES     (STAGES),
      .FILTER_CNT (FILTER_CNT),
      .RST_VAL    (RST_VAL[i])
    ) u_bit (
      .clk  (clk),
      .rstb (rstb),
      .d    (d[i]),
      .o    (o[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  // Pure OR of flop outputs: changes on the same edge as rise/fall.
  assign any_chg = |(rise | fall);

endmodule

// File: tb/tb_ctech_lib_multisync_filt.sv
module tb_ctech_lib_multisync_filt;

  localparam int unsigned A_W = 4;
  localparam int unsigned A_S = 2;
  localparam int unsigned A_F = 0;
  localparam logic [3:0]  A_R = 4'b1010;
  localparam int unsigned B_W = 8;
  localparam int unsigned B_S = 3;
  localparam int unsigned B_F = 3;
  localparam logic [7:0]  B_R = 8'h5A;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic [3:0] da = 4'b0101;
  logic [7:0] db = 8'hA5;
  logic [3:0] oa, ra, fa;
  logic [7:0] ob, rb, fb;
  logic ca, cb;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ctech_lib_multisync_filt #(
    .WIDTH(A_W), .STAGES(A_S), .RST_VAL(A_R), .FILTER_CNT(A_F)
  ) u_dut_a (
    .clk(clk), .rstb(rstb), .d(da), .o(oa), .rise(ra), .fall(fa), .any_chg(ca)
  );

  ctech_lib_multisync_filt #(
    .WIDTH(B_W), .STAGES(B_S), .RST_VAL(B_R), .FILTER_CNT(B_F)
  ) u_dut_b (
    .clk(clk), .rstb(rstb), .d(db), .o(ob), .rise(rb), .fall(fb), .any_chg(cb)
  );

  // Behavioural model: each bit sees its input delayed by STAGES edges;
  // o follows once that delayed value has disagreed with o for F+1 edges.
  int         stg[2]  = '{A_S, B_S};
  int         fc[2]   = '{A_F, B_F};
  int         wd[2]   = '{A_W, B_W};
  logic [7:0] rv[2]   = '{{4'b0, A_R}, B_R};
  logic [7:0] mo[2];
  logic [7:0] mr[2];
  logic [7:0] mf[2];
  logic [7:0] hist[2][4];
  int         streak[2][8];

  task automatic m_reset(input int n);
    mo[n] = rv[n];
    mr[n] = '0;
    mf[n] = '0;
    for (int k = 0; k < 4; k++) hist[n][k] = rv[n];
    for (int b = 0; b < 8; b++) streak[n][b] = 0;
  endtask

  task automatic m_edge(input int n, input logic [7:0] din);
    logic [7:0] s;
    s = hist[n][stg[n]-1];
    mr[n] = '0;
    mf[n] = '0;
    for (int b = 0; b < wd[n]; b++) begin
      if (s[b] == mo[n][b]) begin
        streak[n][b] = 0;
      end else if (streak[n][b] >= fc[n]) begin
        mo[n][b] = s[b];
        if (s[b]) mr[n][b] = 1'b1;
        else mf[n][b] = 1'b1;
        streak[n][b] = 0;
      end else begin
        streak[n][b]++;
      end
    end
    for (int k = 3; k > 0; k--) hist[n][k] = hist[n][k-1];
    hist[n][0] = din;
  endtask

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_reset(0);
      m_reset(1);
    end else begin
      m_edge(0, {4'b0, da});
      m_edge(1, db);
    end
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_o",    {4'b0, oa}, mo[0]);
      check("a_rise", {4'b0, ra}, mr[0]);
      check("a_fall", {4'b0, fa}, mf[0]);
      check("a_chg",  {7'b0, ca}, {7'b0, |(mr[0] | mf[0])});
      check("a_excl", {4'b0, ra & fa}, 8'h00);
      check("b_o",    ob, mo[1]);
      check("b_rise", rb, mr[1]);
      check("b_fall", fb, mf[1]);
      check("b_chg",  {7'b0, cb}, {7'b0, |(mr[1] | mf[1])});
      check("b_excl", rb & fb, 8'h00);
    end
  end

  initial begin
    m_reset(0);
    m_reset(1);
    repeat (3) @(negedge clk);
    check("rst_a_o", {4'b0, oa}, 8'h0A);
    check("rst_b_o", ob, 8'h5A);
    check("rst_a_pulse", {4'b0, ra | fa}, 8'h00);
    check("rst_b_chg", {7'b0, cb}, 8'h00);
    chk_en = 1'b1;

    // Release with every input bit opposite its reset value.
    rstb = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (e == 1) check("rel_no_pulse", {6'b0, ca, cb}, 8'h00);
      if (e == 2) check("rel_a_hold", {4'b0, oa}, 8'h0A);
      if (e == 3) begin
        check("rel_a_o", {4'b0, oa}, 8'h05);
        check("rel_a_rise", {4'b0, ra}, 8'h05);
        check("rel_a_fall", {4'b0, fa}, 8'h0A);
      end
      if (e == 4) check("rel_a_pulse_end", {4'b0, ra | fa}, 8'h00);
      if (e == 6) check("rel_b_hold", ob, 8'h5A);
      if (e == 7) begin
        check("rel_b_o", ob, 8'hA5);
        check("rel_b_rise", rb, 8'hA5);
        check("rel_b_fall", fb, 8'h5A);
      end
    end

    // 3-cycle glitch on db[1] must be rejected.
    db[1] = 1'b1;
    repeat (3) @(negedge clk);
    db[1] = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      check("glitch3_o1", {7'b0, ob[1]}, 8'h00);
    end

    // 4-cycle pulse must pass, o changing at the 4th disagreeing edge.
    db[1] = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      if (j == 4) db[1] = 1'b0;
      if (j == 6) check("pulse4_hold", {7'b0, ob[1]}, 8'h00);
      if (j == 7) begin
        check("pulse4_o1", {7'b0, ob[1]}, 8'h01);
        check("pulse4_rise1", {7'b0, rb[1]}, 8'h01);
      end
    end
    repeat (12) @(negedge clk);

    // Reset while the filter is part-way through a count.
    db[1] = 1'b1;
    repeat (5) @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    check("midrst_b_o", ob, 8'h5A);
    check("midrst_b_pulse", rb | fb, 8'h00);
    @(negedge clk);
    rstb = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      if (e == 6) check("midrst_hold", ob, 8'h5A);
      if (e == 7) begin
        check("midrst_o", ob, 8'hA7);
        check("midrst_rise", rb, 8'hA5);
      end
    end

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 4) == 0) da[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 4) == 0) db[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) db ^= 8'($urandom_range(0, 255)) & 8'h11;
      if ($urandom_range(0, 599) == 0) begin
        #2 rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
      end
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
